// File: rtl/display_scan.sv
// Six-digit multiplexed 7-segment scanner for HH MM SS with a frame-coherent input snapshot.
// Optional field blinking is built only when DISPLAY_SCAN_BLINK_EN is defined.
module display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int LZB          = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       CP,
  input  logic       CR,
  input  logic [3:0] CntH,
  input  logic [3:0] CntL,
  input  logic [7:0] Min,
  input  logic [7:0] Sec,
  input  logic       Colon,
  input  logic [1:0] SetSel,
  output logic [6:0] Seg,
  output logic [5:0] Dig,
  output logic       Dp
);

  localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [3:0]  r_snap_h;
  logic [3:0]  r_snap_l;
  logic [7:0]  r_snap_min;
  logic [7:0]  r_snap_sec;
  logic        r_snap_colon;
  logic        r_load;
  logic [6:0]  r_seg;
  logic [5:0]  r_dig;
  logic        r_dp;

  logic        w_tick;
  logic        w_frame_end;
  logic        w_ghost;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg_dec;
  logic        w_lzb_blank;
  logic        w_dp_raw;
  logic        w_blink_blank;
  logic [5:0]  w_dig_next;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = 7'h40;
    endcase
  endfunction

  assign w_tick      = (r_cnt == CNT_MAX);
  assign w_frame_end = w_tick && (r_idx == 3'd5);
  assign w_ghost     = (r_cnt == 16'd0);

  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      3'd0:    w_digit = r_snap_h;
      3'd1:    w_digit = r_snap_l;
      3'd2:    w_digit = r_snap_min[7:4];
      3'd3:    w_digit = r_snap_min[3:0];
      3'd4:    w_digit = r_snap_sec[7:4];
      3'd5:    w_digit = r_snap_sec[3:0];
      default: w_digit = 4'd0;
    endcase
  end

  assign w_seg_dec   = bcd_to_seg(w_digit);
  assign w_lzb_blank = (LZB == 1) && (r_idx == 3'd0) && (r_snap_h == 4'd0);
  assign w_dp_raw    = r_snap_colon && ((r_idx == 3'd1) || (r_idx == 3'd3));
  assign w_dig_next  = w_ghost ? 6'b111111 : ~(6'b000001 << r_idx);

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] r_frame;
  logic          r_phase;

  always_ff @(posedge CP) begin
    if (CR) begin
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame == FW'(BLINK_FRAMES - 1)) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

  // Each selectable field is a pair of adjacent digit slots.
  assign w_blink_blank = r_phase &&
      (((SetSel == 2'b01) && ((r_idx == 3'd0) || (r_idx == 3'd1))) ||
       ((SetSel == 2'b10) && ((r_idx == 3'd2) || (r_idx == 3'd3))) ||
       ((SetSel == 2'b11) && ((r_idx == 3'd4) || (r_idx == 3'd5))));
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = (^SetSel) ^ (BLINK_FRAMES == 0);
  assign w_blink_blank = 1'b0;
`endif

  always_ff @(posedge CP) begin
    if (CR) begin
      r_cnt        <= 16'd0;
      r_idx        <= 3'd0;
      r_snap_h     <= 4'd0;
      r_snap_l     <= 4'd0;
      r_snap_min   <= 8'd0;
      r_snap_sec   <= 8'd0;
      r_snap_colon <= 1'b0;
      r_load       <= 1'b1;
      r_seg        <= 7'd0;
      r_dig        <= 6'b111111;
      r_dp         <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cnt <= 16'd0;
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end

      // Snapshot only at frame boundaries so a frame never mixes old and new time.
      if (r_load || w_frame_end) begin
        r_snap_h     <= CntH;
        r_snap_l     <= CntL;
        r_snap_min   <= Min;
        r_snap_sec   <= Sec;
        r_snap_colon <= Colon;
      end
      r_load <= 1'b0;

      r_dig <= w_dig_next;
      r_seg <= (w_ghost || w_lzb_blank || w_blink_blank) ? 7'd0 : w_seg_dec;
      r_dp  <= (w_ghost || w_blink_blank) ? 1'b0 : w_dp_raw;
    end
  end

  assign Seg = r_seg;
  assign Dig = r_dig;
  assign Dp  = r_dp;

endmodule
